sdram_port_arbiter: RTL and testbench

//  Shares the single byte-wide CPU port of the SDRAM controller among three requesters:
//  P0 = Z80 CPU, P1 = FDC/tape DMA, P2 = ROM/ioctl loader.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_port_arbiter_if.sv | 29 ++
 rtl/sdram_arb_pick.sv | 36 +++
 rtl/sdram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared constants, FSM encoding and index helper for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int NPORT = 3;
   localparam int P_CPU = 0;
   localparam int P_DMA = 1;
   localparam int P_LDR = 2;

   localparam logic [2:0] PH_LAST = 3'd7;
   localparam logic [2:0] PH_CAP  = 3'd0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } arb_state_e;

   typedef logic [1:0] port_idx_t;

   function automatic port_idx_t idx_inc(port_idx_t i);
      return (i == port_idx_t'(P_LDR)) ? port_idx_t'(P_CPU) : i + 2'd1;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester handshake plus SDRAM CPU-port bus; slave = arbiter side, master = requesters/sdram.
interface sdram_port_arbiter_if #(
   parameter int AW = 23,
   parameter int DW = 8
);
   logic [2:0]      p_req;
   logic [2:0]      p_ack;
   logic [2:0]      p_we;
   logic [3*AW-1:0] p_addr;
   logic [5:0]      p_bank;
   logic [3*DW-1:0] p_din;
   logic [3*DW-1:0] p_dout;
   logic            sd_oe;
   logic            sd_we;
   logic [AW-1:0]   sd_addr;
   logic [1:0]      sd_bank;
   logic [DW-1:0]   sd_din;
   logic [DW-1:0]   sd_dout;

   modport slave (
      input  p_req, p_we, p_addr, p_bank, p_din, sd_dout,
      output p_ack, p_dout, sd_oe, sd_we, sd_addr, sd_bank, sd_din
   );

   modport master (
      output p_req, p_we, p_addr, p_bank, p_din, sd_dout,
      input  p_ack, p_dout, sd_oe, sd_we, sd_addr, sd_bank, sd_din
   );
endinterface

// File: rtl/sdram_arb_pick.sv
// Winner selection over the pending vector: fixed P0>P1>P2, or round-robin
// from the rr pointer when SDRAM_ARB_RR_EN is defined.
module sdram_arb_pick
   import sdram_arb_pkg::*;
(
   input  logic [2:0] pend,
`ifdef SDRAM_ARB_RR_EN
   input  port_idx_t  rr,
`endif
   output logic       any,
   output port_idx_t  gnt
);

   assign any = |pend;

`ifdef SDRAM_ARB_RR_EN
   port_idx_t c1, c2;

   always_comb begin
      c1  = idx_inc(rr);
      c2  = idx_inc(c1);
      gnt = rr;
      if (pend[rr])      gnt = rr;
      else if (pend[c1]) gnt = c1;
      else if (pend[c2]) gnt = c2;
   end
`else
   always_comb begin
      gnt = port_idx_t'(P_CPU);
      if (pend[P_CPU])      gnt = port_idx_t'(P_CPU);
      else if (pend[P_DMA]) gnt = port_idx_t'(P_DMA);
      else if (pend[P_LDR]) gnt = port_idx_t'(P_LDR);
   end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM CPU port among three toggle-handshake requesters, one access per two slots.
// Define SDRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW       = 23,
   parameter int DW       = 8,
   parameter int SLOT_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clkref,
   sdram_port_arbiter_if.slave bus
);

   localparam int PHW = $clog2(SLOT_LEN);

   logic [PHW-1:0] ph, ph_nxt;
   logic           old_ref;
   arb_state_e     state, state_nxt;
   logic           do_grant, do_done, any;
   logic [2:0]     pend, ack;
   port_idx_t      win, gnt;
   logic           oe_r, we_r;
   logic [AW-1:0]  addr_r;
   logic [1:0]     bank_r;
   logic [DW-1:0]  din_r;

   logic [AW-1:0]  addr_v [NPORT];
   logic [1:0]     bank_v [NPORT];
   logic [DW-1:0]  din_v  [NPORT];
   logic [DW-1:0]  dout_v [NPORT];

   for (genvar i = 0; i < NPORT; i++) begin : g_port
      assign addr_v[i] = bus.p_addr[i*AW +: AW];
      assign bank_v[i] = bus.p_bank[i*2 +: 2];
      assign din_v[i]  = bus.p_din[i*DW +: DW];
      assign bus.p_dout[i*DW +: DW] = dout_v[i];
   end

   assign pend = bus.p_req ^ ack;

   // Phase follows the controller: a rising clkref restarts the slot at ph 0.
   assign ph_nxt = (~old_ref & clkref) ? '0 : ph + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph      <= '0;
         old_ref <= 1'b0;
      end else begin
         ph      <= ph_nxt;
         old_ref <= clkref;
      end
   end

`ifdef SDRAM_ARB_RR_EN
   port_idx_t rr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         rr <= '0;
      else if (do_grant) rr <= idx_inc(win);
   end
`endif

   sdram_arb_pick u_pick (
      .pend (pend),
`ifdef SDRAM_ARB_RR_EN
      .rr   (rr),
`endif
      .any  (any),
      .gnt  (win)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ISSUE ends at the next slot start, which also covers an early clkref.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if ((ph == PH_LAST) && any) state_nxt = ISSUE;
         ISSUE:    if (ph_nxt == PH_CAP)       state_nxt = COMPLETE;
         COMPLETE: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      do_grant = 1'b0;
      do_done  = 1'b0;
      case (state)
         IDLE:     do_grant = (ph == PH_LAST) && any;
         COMPLETE: do_done  = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oe_r   <= 1'b0;
         we_r   <= 1'b0;
         addr_r <= '0;
         bank_r <= '0;
         din_r  <= '0;
         gnt    <= '0;
         ack    <= '0;
         for (int i = 0; i < NPORT; i++) dout_v[i] <= '1;
      end else begin
         if (do_grant) begin
            gnt    <= win;
            addr_r <= addr_v[win];
            bank_r <= bank_v[win];
            din_r  <= din_v[win];
            oe_r   <= ~bus.p_we[win];
            we_r   <= bus.p_we[win];
         end
         if (do_done) begin
            oe_r     <= 1'b0;
            we_r     <= 1'b0;
            ack[gnt] <= ~ack[gnt];
            if (!we_r) dout_v[gnt] <= bus.sd_dout;
         end
      end
   end

   assign bus.p_ack   = ack;
   assign bus.sd_oe   = oe_r;
   assign bus.sd_we   = we_r;
   assign bus.sd_addr = addr_r;
   assign bus.sd_bank = bank_r;
   assign bus.sd_din  = din_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: sdram/clkref model, cycle-count reference model and directed tests.
module tb_sdram_port_arbiter;
   localparam int AW = 23;
   localparam int DW = 8;
`ifdef SDRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, clkref = 1'b0;
   int   total = 0, bad = 0, cyc = 0;

   sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   sdram_port_arbiter #(.AW(AW), .DW(DW), .SLOT_LEN(8)) dut (
      .clk(clk), .reset(reset), .clkref(clkref), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // sdram model: byte memory on the low address nibble, writes land while we is high
   logic [7:0] mem [16] = '{5: 8'hA5, default: 8'h11};
   assign bus.sd_dout = mem[bus.sd_addr[3:0]];
   always @(posedge clk) if (bus.sd_we) mem[bus.sd_addr[3:0]] <= bus.sd_din;

   // clkref: one-cycle pulse every 8 clk; early_cnt bumps pull the next pulse 3 clk early
   int refcnt = 0, last_pulse = -100, early_cnt = 0, early_done = 0;
   always @(negedge clk) begin
      if (early_cnt != early_done) begin
         refcnt     = refcnt + 3;
         early_done = early_cnt;
      end
      clkref = (refcnt >= 7);
      if (clkref) begin
         refcnt     = 0;
         last_pulse = cyc;
      end else refcnt++;
   end

   // reference model: one access per grant, completes 9 clk after the grant edge
   function automatic int pick(logic [2:0] p, int rr);
      int s;
      s = RR ? rr : 0;
      for (int k = 0; k < 3; k++) if (p[(s + k) % 3]) return (s + k) % 3;
      return 0;
   endfunction

   logic [2:0]    m_ack = '0, m_pend;
   logic [7:0]    m_dout [3] = '{default: 8'hFF};
   logic          m_busy = 1'b0, m_we = 1'b0, m_ref = 1'b0;
   int            m_cnt = 0, m_gnt = 0, m_rr = 0, m_ph = 0, m_w;
   logic [AW-1:0] m_addr = '0;
   logic [1:0]    m_bank = '0;
   logic [7:0]    m_din = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ack = '0; m_dout = '{default: 8'hFF}; m_busy = 1'b0; m_we = 1'b0;
         m_ref = 1'b0; m_cnt = 0; m_gnt = 0; m_rr = 0; m_ph = 0;
         m_addr = '0; m_bank = '0; m_din = '0;
      end else begin
         m_pend = bus.p_req ^ m_ack;
         if (m_busy) begin
            if (m_cnt == 8) begin
               m_busy = 1'b0;
               m_ack[m_gnt] = ~m_ack[m_gnt];
               if (!m_we) m_dout[m_gnt] = bus.sd_dout;
            end else m_cnt++;
         end else if (m_ph == 7 && m_pend != 0) begin
            m_w    = pick(m_pend, m_rr);
            m_busy = 1'b1;
            m_cnt  = 0;
            m_gnt  = m_w;
            m_we   = bus.p_we[m_w];
            m_addr = bus.p_addr[m_w*AW +: AW];
            m_bank = bus.p_bank[m_w*2 +: 2];
            m_din  = bus.p_din[m_w*DW +: DW];
            m_rr   = (m_w + 1) % 3;
         end
         m_ph  = (!m_ref && clkref) ? 0 : (m_ph + 1) % 8;
         m_ref = clkref;
      end
   end

   // per-cycle compare plus access-shape monitor
   int            run = 0, last_run = 0, rise_cyc = 0;
   int            ack_cyc [3] = '{default: 0};
   logic [2:0]    prev_ack = '0;
   logic [AW-1:0] rise_q [$];
   int            rcyc_q [$];

   always @(negedge clk) begin
      chk("sd_oe",   {31'd0, bus.sd_oe}, {31'd0, m_busy & ~m_we});
      chk("sd_we",   {31'd0, bus.sd_we}, {31'd0, m_busy & m_we});
      chk("sd_addr", 32'(bus.sd_addr), 32'(m_addr));
      chk("sd_bank", 32'(bus.sd_bank), 32'(m_bank));
      chk("sd_din",  32'(bus.sd_din),  32'(m_din));
      chk("p_ack",   32'(bus.p_ack),   32'(m_ack));
      chk("p_dout",  32'(bus.p_dout),  32'({m_dout[2], m_dout[1], m_dout[0]}));
      if (reset) run = 0;
      else if (bus.sd_oe || bus.sd_we) begin
         if (run == 0) begin
            rise_cyc = cyc;
            rise_q.push_back(bus.sd_addr);
            rcyc_q.push_back(cyc);
            chk("slot_align", cyc - last_pulse, 1);
         end
         run++;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
      for (int i = 0; i < 3; i++) if (bus.p_ack[i] != prev_ack[i]) ack_cyc[i] = cyc;
      prev_ack = bus.p_ack;
   end

   task automatic req(int p, bit we, logic [AW-1:0] a, logic [1:0] b, logic [7:0] d);
      bus.p_we[p]             = we;
      bus.p_addr[p*AW +: AW]  = a;
      bus.p_bank[p*2 +: 2]    = b;
      bus.p_din[p*DW +: DW]   = d;
      bus.p_req[p]            = ~bus.p_req[p];
   endtask

   task automatic wait_ack(int p);
      int n = 0;
      while (bus.p_ack[p] != bus.p_req[p] && n < 120) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("ack_timeout_p%0d", p), n, (n < 120) ? n : 0);
   endtask

   initial begin
      int base, n, pre, pulse_c;
      logic [AW-1:0] exp3 [3];
      logic [AW-1:0] exp4 [4];
      bus.p_req = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_bank = '0; bus.p_din = '0;
      repeat (3) @(negedge clk);
      chk("rst_oe",   {31'd0, bus.sd_oe}, 0);
      chk("rst_ack",  32'(bus.p_ack), 0);
      chk("rst_dout", 32'(bus.p_dout), 32'h00FF_FFFF);
      #2 reset = 1'b0;
      repeat (20) @(negedge clk);

      // read on P1
      req(1, 1'b0, 23'h012345, 2'd1, 8'h00);
      wait_ack(1);
      @(negedge clk);
      chk("t1_dout", 32'(bus.p_dout[15:8]), 32'hA5);
      chk("t1_oe_len", last_run, 9);
      chk("t1_ack_lat", ack_cyc[1] - rise_cyc, 9);

      // write on P2, then read it back on P0
      req(2, 1'b1, 23'h00000A, 2'd2, 8'h3C);
      wait_ack(2);
      @(negedge clk);
      chk("t2_we_len", last_run, 9);
      chk("t2_ack_lat", ack_cyc[2] - rise_cyc, 9);
      chk("t2_dout_keep", 32'(bus.p_dout[23:16]), 32'hFF);
      chk("t2_mem", 32'(mem[10]), 32'h3C);
      req(0, 1'b0, 23'h00000A, 2'd0, 8'h00);
      wait_ack(0);
      chk("t2_readback", 32'(bus.p_dout[7:0]), 32'h3C);

      // three simultaneous requests
      base = rise_q.size();
      req(0, 1'b0, 23'h1, 2'd0, 8'h00);
      req(1, 1'b0, 23'h2, 2'd1, 8'h00);
      req(2, 1'b0, 23'h3, 2'd2, 8'h00);
      for (int i = 0; i < 3; i++) wait_ack(i);
      @(negedge clk);
      if (RR) exp3 = '{23'h2, 23'h3, 23'h1};
      else    exp3 = '{23'h1, 23'h2, 23'h3};
      for (int k = 0; k < 3; k++) chk($sformatf("t3_order%0d", k), 32'(rise_q[base+k]), 32'(exp3[k]));
      chk("t3_gap01", rcyc_q[base+1] - rcyc_q[base], 16);
      chk("t3_gap12", rcyc_q[base+2] - rcyc_q[base+1], 16);

      // P0 back to back against a waiting P2
      base = rise_q.size();
      req(0, 1'b0, 23'h4, 2'd0, 8'h00);
      req(2, 1'b0, 23'h6, 2'd2, 8'h00);
      for (int i = 0; i < 3; i++) begin
         wait_ack(0);
         if (i < 2) req(0, 1'b0, 23'h4, 2'd0, 8'h00);
      end
      wait_ack(2);
      @(negedge clk);
      if (RR) exp4 = '{23'h6, 23'h4, 23'h4, 23'h4};
      else    exp4 = '{23'h4, 23'h4, 23'h4, 23'h6};
      for (int k = 0; k < 4; k++) chk($sformatf("t4_order%0d", k), 32'(rise_q[base+k]), 32'(exp4[k]));

      // reset in the middle of an access
      req(0, 1'b0, 23'h5, 2'd0, 8'h00);
      n = 0;
      while (!bus.sd_oe && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t5_oe_seen", n, (n < 40) ? n : 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      bus.p_req = '0;
      #1;
      chk("t5_oe_now", {31'd0, bus.sd_oe}, 0);
      chk("t5_ack_now", 32'(bus.p_ack), 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("t5_no_ack", 32'(bus.p_ack), 0);
      req(0, 1'b0, 23'h5, 2'd0, 8'h00);
      wait_ack(0);
      @(negedge clk);
      chk("t5_dout", 32'(bus.p_dout[7:0]), 32'hA5);
      chk("t5_oe_len", last_run, 9);

      // clkref arriving 3 clk early while idle
      n = 0;
      while ((cyc - last_pulse) != 4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      pre = last_pulse;
      early_cnt++;
      n = 0;
      while (last_pulse == pre && n < 20) begin
         @(negedge clk);
         n++;
      end
      pulse_c = last_pulse;
      chk("t6_early_gap", pulse_c - pre, 5);
      req(1, 1'b0, 23'h012345, 2'd3, 8'h00);
      wait_ack(1);
      @(negedge clk);
      chk("t6_rise", rise_cyc - pulse_c, 9);
      chk("t6_oe_len", last_run, 9);
      chk("t6_dout", 32'(bus.p_dout[15:8]), 32'hA5);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
